// File: rtl/matmul_seq.sv
// Sequencer for C = A x B: walks (i,j,k), issues A/B reads, aligns MAC controls and C writes.
// Optional cycle counter on perf_cycles when MATMUL_SEQ_PERF_EN is defined.
module matmul_seq #(
  parameter int unsigned DIM_W  = 9,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              start,
  input  logic [DIM_W-1:0]  dim_m,
  input  logic [DIM_W-1:0]  dim_n,
  input  logic [DIM_W-1:0]  dim_k,
  input  logic              stall,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] a_addr,
  output logic [ADDR_W-1:0] b_addr,
  output logic              ab_re,
  output logic              mac_en,
  output logic              mac_first,
  output logic              mac_last,
  output logic [ADDR_W-1:0] c_addr,
  output logic              c_we,
  output logic [31:0]       perf_cycles
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRun   = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StFin   = 2'd3;

  localparam int unsigned DrainW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
  localparam logic [DrainW-1:0] DrainLast = DrainW'(RD_LAT);
  localparam logic [DIM_W-1:0]  DOne = DIM_W'(1);
  localparam logic [ADDR_W-1:0] AOne = ADDR_W'(1);
  localparam logic [DrainW-1:0] COne = DrainW'(1);

  logic [1:0]        state_q, state_d;
  logic [DIM_W-1:0]  m_q, m_d, n_q, n_d, k_q, k_d;
  logic [DIM_W-1:0]  i_q, i_d, j_q, j_d, kc_q, kc_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d, a_q, a_d, b_q, b_d, c_q, c_d;
  logic              err_q, err_d;
  logic [DrainW-1:0] drain_q, drain_d;

  logic              issue;
  logic              last_i, last_j, last_k;
  logic              zero_dim;
  logic [ADDR_W-1:0] k_ext, n_ext, j_ext;

  // Tag pipeline: one slot per cycle of read latency.
  logic [RD_LAT-1:0] tv_q, tf_q, tl_q;
  logic [ADDR_W-1:0] tc_q [RD_LAT];
  logic              cwe_q;
  logic [ADDR_W-1:0] caddr_q;

  assign issue    = (state_q == StRun) && !stall;
  assign last_i   = (i_q == m_q - DOne);
  assign last_j   = (j_q == n_q - DOne);
  assign last_k   = (kc_q == k_q - DOne);
  assign zero_dim = (dim_m == '0) || (dim_n == '0) || (dim_k == '0);
  assign k_ext    = ADDR_W'(k_q);
  assign n_ext    = ADDR_W'(n_q);
  assign j_ext    = ADDR_W'(j_q);

  always_comb begin
    state_d  = state_q;
    m_d      = m_q;
    n_d      = n_q;
    k_d      = k_q;
    i_d      = i_q;
    j_d      = j_q;
    kc_d     = kc_q;
    a_base_d = a_base_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    err_d    = err_q;
    drain_d  = drain_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          m_d      = dim_m;
          n_d      = dim_n;
          k_d      = dim_k;
          i_d      = '0;
          j_d      = '0;
          kc_d     = '0;
          a_base_d = '0;
          a_d      = '0;
          b_d      = '0;
          c_d      = '0;
          err_d    = zero_dim;
          state_d  = zero_dim ? StFin : StRun;
        end
      end
      StRun: begin
        if (!stall) begin
          if (!last_k) begin
            kc_d = kc_q + DOne;
            a_d  = a_q + AOne;
            b_d  = b_q + n_ext;
          end else begin
            kc_d = '0;
            c_d  = c_q + AOne;
            if (!last_j) begin
              j_d = j_q + DOne;
              a_d = a_base_q;
              b_d = j_ext + AOne;
            end else begin
              // Row of C finished: advance A to the next row base.
              j_d      = '0;
              i_d      = i_q + DOne;
              a_base_d = a_base_q + k_ext;
              a_d      = a_base_q + k_ext;
              b_d      = '0;
              if (last_i) begin
                state_d = StDrain;
                drain_d = '0;
              end
            end
          end
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StFin;
        end else begin
          drain_d = drain_q + COne;
        end
      end
      StFin: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      m_q      <= '0;
      n_q      <= '0;
      k_q      <= '0;
      i_q      <= '0;
      j_q      <= '0;
      kc_q     <= '0;
      a_base_q <= '0;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= '0;
      err_q    <= 1'b0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      m_q      <= m_d;
      n_q      <= n_d;
      k_q      <= k_d;
      i_q      <= i_d;
      j_q      <= j_d;
      kc_q     <= kc_d;
      a_base_q <= a_base_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      err_q    <= err_d;
      drain_q  <= drain_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tv_q    <= '0;
      tf_q    <= '0;
      tl_q    <= '0;
      for (int s = 0; s < int'(RD_LAT); s++) begin
        tc_q[s] <= '0;
      end
      cwe_q   <= 1'b0;
      caddr_q <= '0;
    end else begin
      tv_q[0] <= issue;
      tf_q[0] <= (kc_q == '0);
      tl_q[0] <= last_k;
      tc_q[0] <= c_q;
      for (int s = 1; s < int'(RD_LAT); s++) begin
        tv_q[s] <= tv_q[s-1];
        tf_q[s] <= tf_q[s-1];
        tl_q[s] <= tl_q[s-1];
        tc_q[s] <= tc_q[s-1];
      end
      cwe_q <= mac_en && mac_last;
      if (mac_en && mac_last) begin
        caddr_q <= tc_q[RD_LAT-1];
      end
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFin);
  assign err       = done && err_q;
  assign ab_re     = issue;
  assign a_addr    = a_q;
  assign b_addr    = b_q;
  assign mac_en    = tv_q[RD_LAT-1];
  assign mac_first = tv_q[RD_LAT-1] && tf_q[RD_LAT-1];
  assign mac_last  = tv_q[RD_LAT-1] && tl_q[RD_LAT-1];
  assign c_we      = cwe_q;
  assign c_addr    = caddr_q;

`ifdef MATMUL_SEQ_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      perf_q <= '0;
    end else if (start && (state_q == StIdle)) begin
      perf_q <= '0;
    end else if (state_q != StIdle) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'h0;
`endif

endmodule

// File: tb/tb_matmul_seq.sv
// Bench for matmul_seq: directed vector table, reset/restart sequences, random jobs vs a
// loop-level reference model of the issue/MAC/write schedule.
module tb_matmul_seq;

  localparam int RD_LAT = 2;
  localparam int MAXC   = 512;

  logic        CLK = 1'b0;
  logic        RST;
  logic        start;
  logic [8:0]  dim_m, dim_n, dim_k;
  logic        stall;
  logic        busy, done, err, ab_re, mac_en, mac_first, mac_last, c_we;
  logic [15:0] a_addr, b_addr, c_addr;
  logic [31:0] perf_cycles;

  matmul_seq #(.DIM_W(9), .ADDR_W(16), .RD_LAT(RD_LAT)) dut (
    .CLK         (CLK),
    .RST         (RST),
    .start       (start),
    .dim_m       (dim_m),
    .dim_n       (dim_n),
    .dim_k       (dim_k),
    .stall       (stall),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .a_addr      (a_addr),
    .b_addr      (b_addr),
    .ab_re       (ab_re),
    .mac_en      (mac_en),
    .mac_first   (mac_first),
    .mac_last    (mac_last),
    .c_addr      (c_addr),
    .c_we        (c_we),
    .perf_cycles (perf_cycles)
  );

  always #5 CLK = ~CLK;

  typedef struct packed {
    logic        busy, done, err, ab_re, mac_en, mac_first, mac_last, c_we;
    logic [15:0] a_addr, b_addr, c_addr;
  } obs_t;

  typedef struct {
    int   m, n, k;
    int   st_lo, st_hi;
    int   restart;
    int   exp_done;
    logic exp_err;
    int   exp_cwe;
  } vec_t;

  obs_t exp_tr [MAXC];
  obs_t act_tr [MAXC];
  logic stall_pat [MAXC];
  int   exp_done;
  int   run_len;
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Reference schedule from loop semantics: n-th issue is (i,j,k) in k-innermost order.
  task automatic build_model(input int m, input int n, input int k);
    int total, issued, cyc, last_issue, i, j, kk;
    for (int c = 0; c < MAXC; c++) exp_tr[c] = '0;
    total = m * n * k;
    if (total == 0) begin
      exp_done = 1;
      exp_tr[1].busy = 1'b1;
      exp_tr[1].done = 1'b1;
      exp_tr[1].err  = 1'b1;
      return;
    end
    issued = 0;
    cyc = 1;
    last_issue = 1;
    while (issued < total && cyc < MAXC - 8) begin
      if (!stall_pat[cyc]) begin
        i  = issued / (n * k);
        j  = (issued / k) % n;
        kk = issued % k;
        exp_tr[cyc].ab_re  = 1'b1;
        exp_tr[cyc].a_addr = 16'(i * k + kk);
        exp_tr[cyc].b_addr = 16'(kk * n + j);
        exp_tr[cyc+RD_LAT].mac_en    = 1'b1;
        exp_tr[cyc+RD_LAT].mac_first = (kk == 0);
        exp_tr[cyc+RD_LAT].mac_last  = (kk == k - 1);
        if (kk == k - 1) begin
          exp_tr[cyc+RD_LAT+1].c_we   = 1'b1;
          exp_tr[cyc+RD_LAT+1].c_addr = 16'(i * n + j);
        end
        issued++;
        last_issue = cyc;
      end
      cyc++;
    end
    exp_done = last_issue + RD_LAT + 2;
    for (int c = 1; c <= exp_done; c++) exp_tr[c].busy = 1'b1;
    exp_tr[exp_done].done = 1'b1;
  endtask

  task automatic run_job(input int m, input int n, input int k, input int restart);
    build_model(m, n, k);
    if (restart > exp_done) restart = -1;
    run_len = exp_done + 4;
    for (int c = 0; c < run_len; c++) begin
      @(posedge CLK);
      #1;
      start = (c == 0) || (c == restart);
      if (c == 0) begin
        dim_m = 9'(m);
        dim_n = 9'(n);
        dim_k = 9'(k);
      end else begin
        dim_m = 9'($urandom);
        dim_n = 9'($urandom);
        dim_k = 9'($urandom);
      end
      stall = stall_pat[c];
      @(negedge CLK);
      act_tr[c].busy      = busy;
      act_tr[c].done      = done;
      act_tr[c].err       = err;
      act_tr[c].ab_re     = ab_re;
      act_tr[c].mac_en    = mac_en;
      act_tr[c].mac_first = mac_first;
      act_tr[c].mac_last  = mac_last;
      act_tr[c].c_we      = c_we;
      act_tr[c].a_addr    = a_addr;
      act_tr[c].b_addr    = b_addr;
      act_tr[c].c_addr    = c_addr;
    end
    start = 1'b0;
    stall = 1'b0;
  endtask

  task automatic check_trace(input string name);
    int    bad [4];
    int    first [4];
    string fname [4];
    obs_t  e, a;
    logic  miss [4];
    fname = '{"ctrl", "a_addr", "b_addr", "c_addr"};
    for (int f = 0; f < 4; f++) begin
      bad[f] = 0;
      first[f] = -1;
    end
    for (int c = 0; c < run_len; c++) begin
      e = exp_tr[c];
      a = act_tr[c];
      miss[0] = ({a.busy, a.done, a.err, a.ab_re, a.mac_en, a.c_we} !==
                 {e.busy, e.done, e.err, e.ab_re, e.mac_en, e.c_we}) ||
                (e.mac_en && ({a.mac_first, a.mac_last} !== {e.mac_first, e.mac_last}));
      miss[1] = e.ab_re && (a.a_addr !== e.a_addr);
      miss[2] = e.ab_re && (a.b_addr !== e.b_addr);
      miss[3] = e.c_we && (a.c_addr !== e.c_addr);
      for (int f = 0; f < 4; f++) begin
        if (miss[f]) begin
          bad[f]++;
          if (first[f] < 0) first[f] = c;
        end
      end
    end
    for (int f = 0; f < 4; f++) begin
      tests++;
      if (bad[f] != 0) begin
        fails++;
        $display("FAIL %s %s: %0d cycles differ, first cycle %0d got %h expected %h",
                 name, fname[f], bad[f], first[f], act_tr[first[f]], exp_tr[first[f]]);
      end
    end
  endtask

  function automatic int first_done();
    for (int c = 0; c < run_len; c++) if (act_tr[c].done) return c;
    return -1;
  endfunction

  function automatic int count_cwe();
    int n = 0;
    for (int c = 0; c < run_len; c++) if (act_tr[c].c_we) n++;
    return n;
  endfunction

  function automatic int exp_perf(input int d);
`ifdef MATMUL_SEQ_PERF_EN
    return d;
`else
    return 0 * d;
`endif
  endfunction

  vec_t vecs [5];
  int   t1_a [8];
  int   t1_b [8];
  int   t1_w [4];
  int   nbad;
  int   rm, rn, rk, rr;

  initial begin
    vecs[0] = '{2, 2, 2, 0, -1, -1, 12, 1'b0, 4};
    vecs[1] = '{1, 3, 1, 0, -1, -1, 7,  1'b0, 3};
    vecs[2] = '{2, 2, 2, 3, 5,  -1, 15, 1'b0, 4};
    vecs[3] = '{2, 2, 0, 0, -1, -1, 1,  1'b1, 0};
    vecs[4] = '{2, 2, 2, 0, -1, 6,  12, 1'b0, 4};
    t1_a = '{0, 1, 0, 1, 2, 3, 2, 3};
    t1_b = '{0, 2, 1, 3, 0, 2, 1, 3};
    t1_w = '{5, 7, 9, 11};

    RST = 1'b1;
    start = 1'b0;
    stall = 1'b0;
    dim_m = '0;
    dim_n = '0;
    dim_k = '0;
    repeat (3) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(negedge CLK);
    check("reset_outputs", {busy, done, err, ab_re, mac_en, mac_first, mac_last, c_we,
                            a_addr, b_addr, c_addr, perf_cycles[15:0]}, '0);

    for (int v = 0; v < 5; v++) begin
      for (int c = 0; c < MAXC; c++)
        stall_pat[c] = (c >= vecs[v].st_lo) && (c <= vecs[v].st_hi);
      run_job(vecs[v].m, vecs[v].n, vecs[v].k, vecs[v].restart);
      check($sformatf("vec%0d_done_cycle", v), 64'(first_done()), 64'(vecs[v].exp_done));
      check($sformatf("vec%0d_err", v), 64'(act_tr[vecs[v].exp_done].err), 64'(vecs[v].exp_err));
      check($sformatf("vec%0d_cwe_count", v), 64'(count_cwe()), 64'(vecs[v].exp_cwe));
      check($sformatf("vec%0d_perf", v), 64'(perf_cycles), 64'(exp_perf(vecs[v].exp_done)));
      check_trace($sformatf("vec%0d", v));
      if (v == 0) begin
        nbad = 0;
        for (int c = 0; c < 8; c++)
          if (!act_tr[c+1].ab_re || act_tr[c+1].a_addr != 16'(t1_a[c])) nbad++;
        check("t1_a_list_mismatches", 64'(nbad), 64'd0);
        nbad = 0;
        for (int c = 0; c < 8; c++)
          if (!act_tr[c+1].ab_re || act_tr[c+1].b_addr != 16'(t1_b[c])) nbad++;
        check("t1_b_list_mismatches", 64'(nbad), 64'd0);
        nbad = 0;
        for (int c = 0; c < 4; c++)
          if (!act_tr[t1_w[c]].c_we || act_tr[t1_w[c]].c_addr != 16'(c)) nbad++;
        check("t1_cwe_list_mismatches", 64'(nbad), 64'd0);
      end
    end

    // Reset mid-run aborts silently, then a fresh start reproduces the plain job.
    for (int c = 0; c < MAXC; c++) stall_pat[c] = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      @(posedge CLK);
      #1;
      start = (c == 0);
      dim_m = 9'd2;
      dim_n = 9'd2;
      dim_k = 9'd2;
      RST   = (c == 4);
    end
    @(posedge CLK);
    #1;
    RST = 1'b0;
    start = 1'b0;
    @(negedge CLK);
    check("rst_abort_outputs", {busy, done, err, ab_re, mac_en, mac_first, mac_last, c_we,
                                a_addr, b_addr, c_addr, perf_cycles[15:0]}, '0);
    nbad = 0;
    repeat (10) begin
      @(negedge CLK);
      if (busy || done || c_we || mac_en || ab_re) nbad++;
    end
    check("rst_abort_quiet_cycles", 64'(nbad), 64'd0);
    run_job(2, 2, 2, -1);
    check("post_rst_done_cycle", 64'(first_done()), 64'd12);
    check_trace("post_rst");

    // Random jobs against the loop-level model.
    for (int r = 0; r < 14; r++) begin
      rm = $urandom_range(1, 4);
      rn = $urandom_range(1, 4);
      rk = $urandom_range(1, 4);
      if (r % 6 == 5) begin
        case ($urandom_range(0, 2))
          0: rm = 0;
          1: rn = 0;
          default: rk = 0;
        endcase
      end
      for (int c = 0; c < MAXC; c++) stall_pat[c] = ($urandom_range(0, 3) == 0);
      rr = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : -1;
      run_job(rm, rn, rk, rr);
      check($sformatf("rnd%0d_done_cycle", r), 64'(first_done()), 64'(exp_done));
      check($sformatf("rnd%0d_perf", r), 64'(perf_cycles), 64'(exp_perf(exp_done)));
      check_trace($sformatf("rnd%0d_m%0d_n%0d_k%0d", r, rm, rn, rk));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
